instruction_fetch_unit: RTL and testbench



---
 rtl/ifu_pkg.sv | 20 ++
 rtl/instruction_fetch_unit_if.sv | 29 ++
 rtl/ifu_next_pc.sv | 52 +++++
 rtl/instruction_fetch_unit.sv | 102 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch state enum, the per-cycle action decoded by ifu_next_pc, and the NOP encoding.
package ifu_pkg;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        RUN,
        DONE,
        FAULT
    } ifu_state_e;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_FETCH,
        ACT_REDIRECT,
        ACT_END,
        ACT_FAULT
    } ifu_act_e;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory, the redirect logic and the decoder.
// The master modport is the fetch unit; the slave modport is everything around it.
interface instruction_fetch_unit_if #(
    parameter int XLEN = 64
);
    import ifu_pkg::*;

    logic [XLEN-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               id_ready;
    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic [XLEN-1:0]    id_pc;
    logic [XLEN-1:0]    id_pc_plus4;
    logic               fetch_done;
    logic               fetch_fault;

    modport master (
        input  imem_rdata, redirect_valid, redirect_pc, id_ready,
        output imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, fetch_done, fetch_fault
    );

    modport slave (
        output imem_rdata, redirect_valid, redirect_pc, id_ready,
        input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, fetch_done, fetch_fault
    );
endinterface

// File: rtl/ifu_next_pc.sv
// Combinational next-pc and action decode: redirect beats stall beats fetch beats end-of-range.
// With IFU_MISALIGN_TRAP_EN defined, a redirect whose low two bits are set traps instead.
module ifu_next_pc
    import ifu_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int MEM_BYTES = 88
) (
    input  ifu_state_e      state,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output ifu_act_e        act
);
    // Last byte address at which a full word can still be fetched; the compare is unsigned.
    localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_BYTES - 4);

    logic misaligned;

`ifdef IFU_MISALIGN_TRAP_EN
    assign misaligned = |redirect_pc[1:0];
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        act     = ACT_HOLD;
        pc_next = pc;
        case (state)
            RUN, DONE: begin
                if (redirect_valid) begin
                    if (misaligned) begin
                        act = ACT_FAULT;
                    end else begin
                        act     = ACT_REDIRECT;
                        pc_next = redirect_pc & ~XLEN'(3);
                    end
                end else if (state == RUN && advance) begin
                    if (pc <= LAST_PC) begin
                        act     = ACT_FETCH;
                        pc_next = pc + XLEN'(4);
                    end else begin
                        act = ACT_END;
                    end
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the pc, the fetch state and the IF/ID pipeline register.
// Optional misaligned-redirect trap is enabled by defining IFU_MISALIGN_TRAP_EN.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              MEM_BYTES = 88
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_fetch_unit_if.master  bus
);
    ifu_state_e         state_reg;
    logic [XLEN-1:0]    pc_reg;
    logic               id_valid_reg;
    logic [INSTR_W-1:0] id_instr_reg;
    logic [XLEN-1:0]    id_pc_reg;
    logic [XLEN-1:0]    id_pc_plus4_reg;
    logic               fetch_done_reg;

    logic               advance;
    logic [XLEN-1:0]    pc_next;
    ifu_act_e           act;

    assign advance = !id_valid_reg || bus.id_ready;

    ifu_next_pc #(
        .XLEN      (XLEN),
        .MEM_BYTES (MEM_BYTES)
    ) u_next_pc (
        .state          (state_reg),
        .redirect_valid (bus.redirect_valid),
        .redirect_pc    (bus.redirect_pc),
        .advance        (advance),
        .pc             (pc_reg),
        .pc_next        (pc_next),
        .act            (act)
    );

`ifdef IFU_MISALIGN_TRAP_EN
    logic fetch_fault_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_fault_reg <= 1'b0;
        end else if (act == ACT_FAULT) begin
            fetch_fault_reg <= 1'b1;
        end
    end

    assign bus.fetch_fault = fetch_fault_reg;
`else
    assign bus.fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= RUN;
            pc_reg          <= RESET_PC;
            id_valid_reg    <= 1'b0;
            id_instr_reg    <= NOP_INSTR;
            id_pc_reg       <= '0;
            id_pc_plus4_reg <= '0;
            fetch_done_reg  <= 1'b0;
        end else begin
            case (act)
                ACT_FETCH: begin
                    id_instr_reg    <= bus.imem_rdata;
                    id_pc_reg       <= pc_reg;
                    id_pc_plus4_reg <= pc_next;
                    id_valid_reg    <= 1'b1;
                    pc_reg          <= pc_next;
                end
                // Flushes whatever is held; a same-cycle decoder accept has already happened.
                ACT_REDIRECT: begin
                    pc_reg         <= pc_next;
                    id_valid_reg   <= 1'b0;
                    state_reg      <= RUN;
                    fetch_done_reg <= 1'b0;
                end
                ACT_END: begin
                    id_valid_reg   <= 1'b0;
                    state_reg      <= DONE;
                    fetch_done_reg <= 1'b1;
                end
                ACT_FAULT: begin
                    id_valid_reg <= 1'b0;
                    state_reg    <= FAULT;
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_addr   = pc_reg;
    assign bus.id_valid    = id_valid_reg;
    assign bus.id_instr    = id_instr_reg;
    assign bus.id_pc       = id_pc_reg;
    assign bus.id_pc_plus4 = id_pc_plus4_reg;
    assign bus.fetch_done  = fetch_done_reg;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios with literal expectations
// plus a spec-level reference model compared on every falling clock edge.
module tb_instruction_fetch_unit;
    localparam int          XLEN      = 64;
    localparam int          MEM_BYTES = 88;
    localparam logic [63:0] LAST_PC   = 64'd84;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [32];

    instruction_fetch_unit_if #(.XLEN(XLEN)) bus ();

    instruction_fetch_unit #(
        .XLEN      (XLEN),
        .RESET_PC  (64'h0),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.imem_rdata = (bus.imem_addr < 64'(MEM_BYTES)) ? prog[bus.imem_addr[6:2]] : 32'h0;

    // Reference model: the fetch unit as seen from outside, one transaction per clock.
    logic [63:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [63:0] m_idpc;
    logic [63:0] m_plus4;
    logic        m_done;
    logic        m_fault;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 64'h0; m_valid <= 1'b0; m_instr <= 32'h00000013;
            m_idpc <= 64'h0; m_plus4 <= 64'h0; m_done <= 1'b0; m_fault <= 1'b0;
        end else if (m_fault) begin
            m_valid <= 1'b0;
        end else if (bus.redirect_valid) begin
`ifdef IFU_MISALIGN_TRAP_EN
            if (bus.redirect_pc % 4 != 0) begin
                m_fault <= 1'b1;
                m_valid <= 1'b0;
            end else begin
                m_pc <= bus.redirect_pc; m_valid <= 1'b0; m_done <= 1'b0;
            end
`else
            m_pc <= bus.redirect_pc - (bus.redirect_pc % 4);
            m_valid <= 1'b0;
            m_done <= 1'b0;
`endif
        end else if (m_done) begin
            m_valid <= 1'b0;
        end else if (m_valid && !bus.id_ready) begin
            m_valid <= m_valid;
        end else if (m_pc <= LAST_PC) begin
            m_instr <= prog[m_pc[6:2]];
            m_idpc  <= m_pc;
            m_plus4 <= m_pc + 64'd4;
            m_valid <= 1'b1;
            m_pc    <= m_pc + 64'd4;
        end else begin
            m_valid <= 1'b0;
            m_done  <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp, input bit quiet);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end else if (!quiet) begin
            $display("check %s = %h t=%0t", name, act, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model imem_addr", bus.imem_addr, m_pc, 1'b1);
        chk("model id_valid", 64'(bus.id_valid), 64'(m_valid), 1'b1);
        chk("model fetch_done", 64'(bus.fetch_done), 64'(m_done), 1'b1);
        chk("model fetch_fault", 64'(bus.fetch_fault), 64'(m_fault), 1'b1);
        if (m_valid) begin
            chk("model id_instr", 64'(bus.id_instr), 64'(m_instr), 1'b1);
            chk("model id_pc", bus.id_pc, m_idpc, 1'b1);
            chk("model id_pc_plus4", bus.id_pc_plus4, m_plus4, 1'b1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [63:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        prog = '{default: 32'h0};
        prog[0]  = 32'h00000913; prog[1]  = 32'h00000433; prog[2]  = 32'h04b40863;
        prog[3]  = 32'h00a00593; prog[4]  = 32'h00b50633; prog[5]  = 32'h40c586b3;
        prog[6]  = 32'h00d67733; prog[7]  = 32'h00e6e7b3; prog[8]  = 32'h00f74833;
        prog[9]  = 32'h01079893; prog[10] = 32'h0108d913; prog[11] = 32'h00140413;
        prog[12] = 32'hfe0418e3; prog[13] = 32'h00100513; prog[14] = 32'h00a00023;
        prog[15] = 32'h00002583; prog[16] = 32'h00458613; prog[17] = 32'h00c00693;
        prog[18] = 32'h00d60733; prog[19] = 32'h00e007b3; prog[20] = 32'h00890913;
        prog[21] = 32'hfa000ae3;

        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.id_ready       = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        chk("reset id_valid", 64'(bus.id_valid), 64'h0, 1'b0);
        chk("reset imem_addr", bus.imem_addr, 64'h0, 1'b0);
        chk("reset id_instr", 64'(bus.id_instr), 64'h13, 1'b0);
        chk("reset id_pc_plus4", bus.id_pc_plus4, 64'h0, 1'b0);
        chk("reset fetch_done", 64'(bus.fetch_done), 64'h0, 1'b0);
        chk("reset fetch_fault", 64'(bus.fetch_fault), 64'h0, 1'b0);
        rst_n = 1'b1;

        // In-order fetch from RESET_PC
        step();
        chk("s1 id_instr0", 64'(bus.id_instr), 64'h00000913, 1'b0);
        chk("s1 id_pc0", bus.id_pc, 64'h0, 1'b0);
        chk("s1 plus4_0", bus.id_pc_plus4, 64'h4, 1'b0);
        chk("s1 id_valid", 64'(bus.id_valid), 64'h1, 1'b0);
        step();
        chk("s1 id_instr1", 64'(bus.id_instr), 64'h00000433, 1'b0);
        chk("s1 id_pc1", bus.id_pc, 64'h4, 1'b0);
        chk("s1 plus4_1", bus.id_pc_plus4, 64'h8, 1'b0);

        // Back-pressure while id_pc = 4
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s2 hold id_instr", 64'(bus.id_instr), 64'h00000433, 1'b0);
            chk("s2 hold imem_addr", bus.imem_addr, 64'h8, 1'b0);
        end
        bus.id_ready = 1'b1;
        step();
        chk("s2 release id_instr", 64'(bus.id_instr), 64'h04b40863, 1'b0);
        chk("s1 id_pc2", bus.id_pc, 64'h8, 1'b0);
        chk("s1 plus4_2", bus.id_pc_plus4, 64'hc, 1'b0);

        // Redirect during a stall
        bus.id_ready = 1'b0;
        step();
        redirect_to(64'h50);
        chk("s3 flush id_valid", 64'(bus.id_valid), 64'h0, 1'b0);
        chk("s3 imem_addr", bus.imem_addr, 64'h50, 1'b0);
        bus.id_ready = 1'b1;
        step();
        chk("s3 target instr", 64'(bus.id_instr), 64'h00890913, 1'b0);
        chk("s3 target pc", bus.id_pc, 64'h50, 1'b0);

        // End of program at the last legal word
        step();
        chk("s4 last instr", 64'(bus.id_instr), 64'hfa000ae3, 1'b0);
        chk("s4 last pc", bus.id_pc, 64'h54, 1'b0);
        step();
        chk("s4 imem_addr", bus.imem_addr, 64'h58, 1'b0);
        chk("s4 fetch_done", 64'(bus.fetch_done), 64'h1, 1'b0);
        chk("s4 id_valid", 64'(bus.id_valid), 64'h0, 1'b0);
        step();
        chk("s4 done sticky", 64'(bus.fetch_done), 64'h1, 1'b0);
        redirect_to(64'h4);
        chk("s4 done cleared", 64'(bus.fetch_done), 64'h0, 1'b0);
        step();
        chk("s4 resume instr", 64'(bus.id_instr), 64'h00000433, 1'b0);
        chk("s4 resume pc", bus.id_pc, 64'h4, 1'b0);

        // Redirect to the top of the address space: out of range, no fetch
        redirect_to(64'hffff_ffff_ffff_fffc);
        chk("wrap imem_addr", bus.imem_addr, 64'hffff_ffff_ffff_fffc, 1'b0);
        step();
        chk("wrap fetch_done", 64'(bus.fetch_done), 64'h1, 1'b0);
        chk("wrap id_valid", 64'(bus.id_valid), 64'h0, 1'b0);
        redirect_to(64'h0);
        step();
        step();
        chk("restart pc", bus.id_pc, 64'h4, 1'b0);

        // Misaligned redirect, concurrent with a decoder accept
        redirect_to(64'h52);
`ifdef IFU_MISALIGN_TRAP_EN
        chk("s5 fetch_fault", 64'(bus.fetch_fault), 64'h1, 1'b0);
        chk("s5 imem_addr held", bus.imem_addr, 64'h8, 1'b0);
        for (int i = 0; i < 10; i++) begin
            redirect_to(64'(i) * 64'h10);
            chk("s5 fault sticky", 64'(bus.fetch_fault), 64'h1, 1'b0);
            chk("s5 id_valid", 64'(bus.id_valid), 64'h0, 1'b0);
        end
`else
        chk("s5 aligned addr", bus.imem_addr, 64'h50, 1'b0);
        step();
        chk("s5 instr", 64'(bus.id_instr), 64'h00890913, 1'b0);
        chk("s5 pc", bus.id_pc, 64'h50, 1'b0);
        chk("s5 fetch_fault", 64'(bus.fetch_fault), 64'h0, 1'b0);
`endif

        // Asynchronous reset between edges during a stall
        bus.id_ready = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("s6 id_valid", 64'(bus.id_valid), 64'h0, 1'b0);
        chk("s6 imem_addr", bus.imem_addr, 64'h0, 1'b0);
        chk("s6 fetch_done", 64'(bus.fetch_done), 64'h0, 1'b0);
        chk("s6 fetch_fault", 64'(bus.fetch_fault), 64'h0, 1'b0);
        rst_n = 1'b1;
        bus.id_ready = 1'b1;
        step();
        chk("s6 refetch instr", 64'(bus.id_instr), 64'h00000913, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
